hp_nvme_cmd_bridge: RTL
=======================

// Module: hp_nvme_cmd_bridge
// PURPOSE
//  AXI4 slave that sits directly downstream of the benchmark kernel's HP master port.
//  Converts each AW/AR burst into one in-order NVMe-style block command for the driver.
//  Forwards write beats to the driver and read beats from it.
//  Turns driver completions back into AXI B responses; R beats get a locally generated rlast.
// PARAMETERS
//  ADDR_WIDTH   48  AXI address width
//  DATA_WIDTH   128 AXI/driver data width (16B beat)
//  LBA_SHIFT    12  log2(LBA bytes); cmd_lba = addr >> LBA_SHIFT
//  MAX_OUTST    8   max issued-but-uncompleted commands (power of 2)
// PORTS
//  clk            in   1    clock
//  rstn           in   1    async active-low reset
//  s_awaddr/awlen/awvalid/awready  in/in/in/out  ADDR_WIDTH/8/1/1  write address
//  s_wdata/wlast/wvalid/wready     in/in/in/out  DATA_WIDTH/1/1/1  write data
//  s_bresp/bvalid/bready           out/out/in    2/1/1             write response
//  s_araddr/arlen/arvalid/arready  in/in/in/out  ADDR_WIDTH/8/1/1  read address
//  s_rdata/rresp/rlast/rvalid/rready out/out/out/out/in  DATA_WIDTH/2/1/1/1  read data
//  cmd_valid/cmd_ready  out/in  1/1              command handshake to driver
//  cmd_write      out  1                        1=write, 0=read
//  cmd_lba        out  ADDR_WIDTH-LBA_SHIFT     starting LBA
//  cmd_nbeats     out  9                        burst beats = len+1 (1..256)
//  wr_data/wr_last/wr_valid/wr_ready  out/out/out/in  DATA_WIDTH/1/1/1
//  rd_data/rd_valid/rd_ready          in/in/out       DATA_WIDTH/1/1
//  cpl_valid/cpl_ready/cpl_status     in/out/in       1/1/2   in-order completions
//  err_unaligned  out  1                        sticky: misaligned addr or length
// BEHAVIOUR
//  - Reset: all valids 0; err_unaligned 0; outstanding=0; FIFOs empty; FSM IDLE.
//    Reset mid-burst discards all in-flight state. No B/R is produced for it.
//  - FSM IDLE/ISSUE:
//    - IDLE: awready or arready=1 only when outstanding<MAX_OUTST and tag FIFO not full.
//    - If both AW and AR are valid, grant the opposite of the last grant (reset: write first).
//    - Handshake captures addr/len/dir and moves to ISSUE; cmd_valid=1 from the next cycle.
//    - ISSUE: cmd fields held stable until cmd_ready; then back to IDLE.
//    - One accepted burst per 2 cycles minimum.
//  - On cmd handshake: push {dir,nbeats} into tag FIFO (depth MAX_OUTST).
//    A read also pushes nbeats into the read-length FIFO.
//  - outstanding: +1 on cmd handshake, -1 on cpl handshake; both in the same cycle -> unchanged.
//  - Alignment:
//    - Set err_unaligned if addr[LBA_SHIFT-1:0]!=0 or ((len+1)*16) mod 2^LBA_SHIFT != 0.
//    - The command is still issued with the truncated LBA. err_unaligned clears only on reset.
//  - W path: 1-entry register stage.
//    - wready = ~wr_valid | wr_ready; wr_last = registered wlast. Latency 1 cycle.
//    - Full throughput. W beats are independent of AW ordering (driver pairs them).
//  - B path:
//    - cpl at tag-FIFO head with dir=write -> bvalid next cycle.
//    - bresp = (cpl_status!=0) ? 2'b10 : 2'b00.
//    - cpl_ready = 0 when head is write and bvalid & ~bready; otherwise cpl_ready=1.
//    - Read completions pop the tag only. Any nonzero status on a read sets rresp=2'b10
//      on later beats of that burst (sticky until its rlast).
//  - R path: rd_* to s_r* through a 1-entry register stage.
//    - Beat counter loads from read-length FIFO head.
//    - rlast=1 on the beat where count==nbeats; then pop the FIFO and reset the counter.
//    - rd_ready=0 when the length FIFO is empty (data before a command is not accepted).
//  - Counters/arith: nbeats = {1'b0,len}+1 (9 bits, no overflow). Outstanding width clog2(MAX_OUTST)+1.
// TESTING
//  - Write 4KB at 0x1000, len=255 -> cmd write lba=1 nbeats=256; 256 wr beats, last on beat 256.
//    cpl status 0 -> bresp 0.
//  - Read 4KB at 0x3000, len=255; driver returns 256 beats -> rlast only on beat 256.
//    cpl pops tag; outstanding returns to 0.
//  - AW and AR valid in the same cycle twice -> order write, read, write, read.
//  - Issue 8 cmds with no cpl -> awready/arready held 0; one cpl releases one more.
//    cpl+cmd in the same cycle leaves outstanding at 8.
//  - awaddr=0x1010 -> err_unaligned=1, cmd lba=1. Write cpl status=1 with bready=0
//    -> bresp=2, cpl_ready=0 until bready.
//  - Assert rstn low mid-burst (beat 100) -> all valids 0 next cycle; err_unaligned 0;
//    new burst after reset completes cleanly.

Source files
------------

// File: rtl/hp_nvme_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hp_nvme_cmd_bridge
// Purpose  : AXI4 slave that turns AW/AR bursts into in-order block commands,
//            forwards W/R beats, and maps completions back to B responses.
// Revision : 1.0 - initial release
// ============================================================================

module hp_nvme_cmd_bridge_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   localparam int              c_PW    = $clog2(DEPTH);
   localparam logic [c_PW:0]   c_DEPTH = (c_PW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]  r_wptr;
   logic [c_PW-1:0]  r_rptr;
   logic [c_PW:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_DEPTH);
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;
   assign head      = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + c_PW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + c_PW'(1);
         r_count <= r_count + {{c_PW{1'b0}}, w_push_ok} - {{c_PW{1'b0}}, w_pop_ok};
      end
   end
endmodule

module hp_nvme_cmd_bridge #(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 128,
   parameter int LBA_SHIFT  = 12,
   parameter int MAX_OUTST  = 8
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [ADDR_WIDTH-1:0]       s_awaddr,
   input  logic [7:0]                  s_awlen,
   input  logic                        s_awvalid,
   output logic                        s_awready,
   input  logic [DATA_WIDTH-1:0]       s_wdata,
   input  logic                        s_wlast,
   input  logic                        s_wvalid,
   output logic                        s_wready,
   output logic [1:0]                  s_bresp,
   output logic                        s_bvalid,
   input  logic                        s_bready,
   input  logic [ADDR_WIDTH-1:0]       s_araddr,
   input  logic [7:0]                  s_arlen,
   input  logic                        s_arvalid,
   output logic                        s_arready,
   output logic [DATA_WIDTH-1:0]       s_rdata,
   output logic [1:0]                  s_rresp,
   output logic                        s_rlast,
   output logic                        s_rvalid,
   input  logic                        s_rready,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic                        cmd_write,
   output logic [ADDR_WIDTH-LBA_SHIFT-1:0] cmd_lba,
   output logic [8:0]                  cmd_nbeats,
   output logic [DATA_WIDTH-1:0]       wr_data,
   output logic                        wr_last,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   input  logic [DATA_WIDTH-1:0]       rd_data,
   input  logic                        rd_valid,
   output logic                        rd_ready,
   input  logic                        cpl_valid,
   output logic                        cpl_ready,
   input  logic [1:0]                  cpl_status,
   output logic                        err_unaligned
);
   // Length is aligned when the beat count is a multiple of beats-per-LBA.
   localparam int                 c_BEAT_SHIFT = $clog2(DATA_WIDTH/8);
   localparam int                 c_LEN_BITS   = LBA_SHIFT - c_BEAT_SHIFT;
   localparam int                 c_LBA_W      = ADDR_WIDTH - LBA_SHIFT;
   localparam int                 c_OW         = $clog2(MAX_OUTST) + 1;
   localparam logic [c_OW-1:0]    c_MAX_OUTST  = c_OW'(MAX_OUTST);
   localparam logic [0:0]         c_IDLE       = 1'b0;
   localparam logic [0:0]         c_ISSUE      = 1'b1;

   logic [0:0]            r_state;
   logic                  r_last_wr;
   logic [c_OW-1:0]       r_outst;
   logic                  r_cmd_write;
   logic [c_LBA_W-1:0]    r_cmd_lba;
   logic [8:0]            r_cmd_nbeats;
   logic                  r_err;

   logic                  w_tag_full, w_tag_empty;
   logic [9:0]            w_tag_head;
   logic                  w_rlen_full, w_rlen_empty;
   logic [8:0]            w_rlen_head;
   logic                  w_unused_tag;

   logic                  w_can_accept, w_pick_w, w_accept;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [8:0]            w_sel_nbeats;
   logic                  w_misaligned;
   logic                  w_cmd_fire, w_cpl_fire, w_head_write;

   assign w_can_accept = (r_state == c_IDLE) && (r_outst < c_MAX_OUTST) && !w_tag_full && !w_rlen_full;
   assign w_pick_w     = s_awvalid & (~s_arvalid | ~r_last_wr);
   assign s_awready    = w_can_accept & w_pick_w;
   assign s_arready    = w_can_accept & s_arvalid & ~w_pick_w;
   assign w_accept     = w_can_accept & (s_awvalid | s_arvalid);
   assign w_sel_addr   = w_pick_w ? s_awaddr : s_araddr;
   assign w_sel_nbeats = {1'b0, (w_pick_w ? s_awlen : s_arlen)} + 9'd1;
   assign w_misaligned = (w_sel_addr[LBA_SHIFT-1:0] != '0) || (w_sel_nbeats[c_LEN_BITS-1:0] != '0);

   assign cmd_valid     = (r_state == c_ISSUE);
   assign cmd_write     = r_cmd_write;
   assign cmd_lba       = r_cmd_lba;
   assign cmd_nbeats    = r_cmd_nbeats;
   assign err_unaligned = r_err;
   assign w_cmd_fire    = cmd_valid & cmd_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= c_IDLE;
         r_last_wr    <= 1'b0;
         r_cmd_write  <= 1'b0;
         r_cmd_lba    <= '0;
         r_cmd_nbeats <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_state      <= c_ISSUE;
                  r_last_wr    <= w_pick_w;
                  r_cmd_write  <= w_pick_w;
                  r_cmd_lba    <= w_sel_addr[ADDR_WIDTH-1:LBA_SHIFT];
                  r_cmd_nbeats <= w_sel_nbeats;
                  if (w_misaligned) r_err <= 1'b1;
               end
            end
            c_ISSUE: if (cmd_ready) r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   hp_nvme_cmd_bridge_fifo #(.WIDTH(10), .DEPTH(MAX_OUTST)) u_tag_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (w_cmd_fire),
      .push_data ({r_cmd_write, r_cmd_nbeats}),
      .pop       (w_cpl_fire),
      .head      (w_tag_head),
      .empty     (w_tag_empty),
      .full      (w_tag_full)
   );
   assign w_unused_tag = ^w_tag_head[8:0];

   // Outstanding tracks issued-but-uncompleted commands.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_outst <= '0;
      end else begin
         case ({w_cmd_fire, w_cpl_fire})
            2'b10:   r_outst <= r_outst + c_OW'(1);
            2'b01:   r_outst <= r_outst - c_OW'(1);
            default: r_outst <= r_outst;
         endcase
      end
   end

   // ---------------- W path ----------------
   logic                  r_wvalid, r_wlast;
   logic [DATA_WIDTH-1:0] r_wdata;

   assign s_wready = ~r_wvalid | wr_ready;
   assign wr_valid = r_wvalid;
   assign wr_data  = r_wdata;
   assign wr_last  = r_wlast;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wvalid <= 1'b0;
         r_wlast  <= 1'b0;
         r_wdata  <= '0;
      end else if (s_wready) begin
         r_wvalid <= s_wvalid;
         if (s_wvalid) begin
            r_wdata <= s_wdata;
            r_wlast <= s_wlast;
         end
      end
   end

   // ---------------- B path ----------------
   logic       r_bvalid;
   logic [1:0] r_bresp;

   assign w_head_write = ~w_tag_empty & w_tag_head[9];
   assign cpl_ready    = ~(w_head_write & r_bvalid & ~s_bready);
   assign w_cpl_fire   = cpl_valid & cpl_ready & ~w_tag_empty;
   assign s_bvalid     = r_bvalid;
   assign s_bresp      = r_bresp;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bvalid <= 1'b0;
         r_bresp  <= 2'b00;
      end else if (w_cpl_fire && w_head_write) begin
         r_bvalid <= 1'b1;
         r_bresp  <= (cpl_status != 2'b00) ? 2'b10 : 2'b00;
      end else if (s_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // ---------------- R path ----------------
   logic                  r_rvalid, r_rlast, r_rd_err;
   logic [1:0]            r_rresp;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [8:0]            r_rcnt;
   logic                  w_rd_fire, w_rd_last, w_rd_err_set;

   hp_nvme_cmd_bridge_fifo #(.WIDTH(9), .DEPTH(MAX_OUTST)) u_rlen_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (w_cmd_fire & ~r_cmd_write),
      .push_data (r_cmd_nbeats),
      .pop       (w_rd_fire & w_rd_last),
      .head      (w_rlen_head),
      .empty     (w_rlen_empty),
      .full      (w_rlen_full)
   );

   assign rd_ready     = ~w_rlen_empty & (~r_rvalid | s_rready);
   assign w_rd_fire    = rd_valid & rd_ready;
   assign w_rd_last    = (r_rcnt == w_rlen_head);
   assign w_rd_err_set = w_cpl_fire & ~w_tag_head[9] & (cpl_status != 2'b00);
   assign s_rvalid     = r_rvalid;
   assign s_rdata      = r_rdata;
   assign s_rlast      = r_rlast;
   assign s_rresp      = r_rresp;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rvalid <= 1'b0;
         r_rlast  <= 1'b0;
         r_rresp  <= 2'b00;
         r_rdata  <= '0;
         r_rcnt   <= 9'd1;
         r_rd_err <= 1'b0;
      end else begin
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= rd_data;
            r_rlast  <= w_rd_last;
            r_rresp  <= r_rd_err ? 2'b10 : 2'b00;
            r_rcnt   <= w_rd_last ? 9'd1 : r_rcnt + 9'd1;
         end else if (s_rready) begin
            r_rvalid <= 1'b0;
         end
         // Error status sticks to the burst in flight until its last beat.
         r_rd_err <= w_rd_err_set | (r_rd_err & ~(w_rd_fire & w_rd_last));
      end
   end
endmodule

`default_nettype wire
